cp_remove: RTL and testbench

- Receive-side cyclic prefix removal stage. It sits downstream of the CP insertion/channel path and upstream of the receive FFT.
- Consumes a sample stream in which each OFDM symbol is cp_length prefix samples followed by fft_length body samples. Discards the prefix, forwards the body with an end-of-symbol marker, and flags framing errors.
- Valid/ready streaming on both sides. One registered output stage.

---
 rtl/cp_remove.sv | 80 ++++++++
 tb/tb_cp_remove.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cp_remove.sv
// cp_remove: drops the cyclic prefix of each OFDM symbol, forwards the body with m_last and flags framing errors.
module cp_remove #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  cp_length,
  input  logic [LEN_W-1:0]  fft_length,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              locked,
  output logic              sync_err,
  output logic              cfg_err
);
  typedef enum logic [1:0] {IDLE, DROP, PASS} state_t;
  state_t state, nxt;
  logic [1:0] rst_q;
  logic rst_s, acc, start, bad_cfg, in_sym, fwd, last;
  logic [LEN_W-1:0] cp_r, fft_r;
  logic [LEN_W:0] idx, idx_nxt, cur_idx, cur_cp, cur_end, idx_inc;
  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or posedge rst)
    if (rst) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign rst_s = rst_q[1];
  assign s_ready = !m_valid || m_ready;
  // A sof beat restarts the symbol in any state, so it uses the live lengths at idx 0.
  always_comb begin
    acc = s_valid && s_ready;
    start = acc && s_sof;
    bad_cfg = start && fft_length == '0;
    cur_idx = start ? '0 : idx;
    cur_cp = {1'b0, start ? cp_length : cp_r};
    cur_end = cur_cp + {1'b0, start ? fft_length : fft_r} - (LEN_W+1)'(1);
    idx_inc = cur_idx + (LEN_W+1)'(1);
    in_sym = acc && (start ? fft_length != '0 : state != IDLE);
    fwd = in_sym && cur_idx >= cur_cp;
    last = fwd && cur_idx == cur_end;
    nxt = !acc ? state : (!in_sym || last) ? IDLE : (idx_inc >= cur_cp) ? PASS : DROP;
    idx_nxt = !acc ? idx : (!in_sym || last) ? '0 : idx_inc;
  end
  always_ff @(posedge clk or posedge rst_s)
    if (rst_s) begin
      state <= IDLE;
      idx <= '0;
      cp_r <= '0;
      fft_r <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      locked <= 1'b0;
      sync_err <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= nxt;
      idx <= idx_nxt;
      if (start) begin
        cp_r <= cp_length;
        fft_r <= fft_length;
      end
      locked <= nxt != IDLE;
      sync_err <= start && state != IDLE;
      cfg_err <= bad_cfg;
      if (fwd) begin
        m_data <= s_data;
        m_valid <= 1'b1;
        m_last <= last;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_cp_remove.sv
// tb_cp_remove: directed checks of prefix removal, backpressure, resync, config errors and async reset.
module tb_cp_remove;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [12:0] cp_length = '0, fft_length = '0;
  logic [31:0] s_data = '0, m_data;
  logic s_valid = 1'b0, s_sof = 1'b0, s_ready;
  logic m_valid, m_last, locked, sync_err, cfg_err;
  logic m_ready = 1'b1;
  int total = 0, bad = 0, ncyc = 0;
  bit bp = 1'b0, acc;
  logic [32:0] got[$];
  cp_remove dut (
    .clk(clk), .rst(rst), .cp_length(cp_length), .fft_length(fft_length),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .locked(locked), .sync_err(sync_err), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock: logs output transfers and checks that stalled outputs hold.
  task automatic tick;
    logic stall, hl;
    logic [31:0] hd;
    if (bp) m_ready = (ncyc % 4 == 0) || (ncyc % 4 == 3);
    #1;
    if (m_valid && m_ready) got.push_back({m_last, m_data});
    stall = m_valid && !m_ready;
    hd = m_data;
    hl = m_last;
    if (stall) check("s_ready_stall", s_ready, 0);
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (stall) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, hd);
      check("hold_last", m_last, hl);
    end
    ncyc++;
  endtask
  task automatic send(input logic [31:0] d, input logic sof);
    s_valid = 1'b1;
    s_data = d;
    s_sof = sof;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) tick();
    if (!acc) check("send_timeout", 0, 1);
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask
  task automatic drain(input int n);
    for (int k = 0; k < 60 && got.size() < n; k++) tick();
    tick();
    check("drain_count", got.size(), n);
  endtask
  task automatic run_basic;
    cp_length = 13'd4;
    fft_length = 13'd8;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      send(i, i == 0);
      check("b_valid", m_valid, i >= 4);
      if (i >= 4) begin
        check("b_data", m_data, i);
        check("b_last", m_last, i == 11);
      end
      check("b_locked", locked, i < 11);
    end
    drain(8);
  endtask
  initial begin
    repeat (2) tick();
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_locked", locked, 0);
    check("rst_errs", {sync_err, cfg_err}, 0);
    rst = 1'b0;
    repeat (3) tick();
    run_basic();
    // Backpressure with m_ready pattern 1,0,0,1
    got.delete();
    ncyc = 0;
    bp = 1'b1;
    for (int i = 0; i < 12; i++) send(i, i == 0);
    drain(8);
    bp = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 8 && k < got.size(); k++) check("bp_out", got[k], {k == 7, 32'(4 + k)});
    // Zero prefix, single sample symbols
    cp_length = 13'd0;
    fft_length = 13'd1;
    for (int i = 0; i < 3; i++) begin
      send(32'hA0 + i, 1'b1);
      check("z_valid", m_valid, 1);
      check("z_data", m_data, 32'hA0 + i);
      check("z_last", m_last, 1);
      check("z_locked", locked, 0);
    end
    tick();
    // Resync: truncated symbol then a full one
    got.delete();
    cp_length = 13'd2;
    fft_length = 13'd4;
    for (int i = 0; i < 4; i++) send(i, i == 0);
    check("r_locked", locked, 1);
    send(10, 1'b1);
    check("r_sync_pulse", sync_err, 1);
    send(11, 1'b0);
    check("r_sync_clear", sync_err, 0);
    for (int i = 12; i < 16; i++) send(i, 1'b0);
    check("r_end_locked", locked, 0);
    drain(6);
    if (got.size() == 6) begin
      check("r_o0", got[0], {1'b0, 32'd2});
      check("r_o1", got[1], {1'b0, 32'd3});
      check("r_o2", got[2], {1'b0, 32'd12});
      check("r_o3", got[3], {1'b0, 32'd13});
      check("r_o4", got[4], {1'b0, 32'd14});
      check("r_o5", got[5], {1'b1, 32'd15});
    end
    // Config error then hunting
    fft_length = 13'd0;
    send(32'h55, 1'b1);
    check("c_cfg_pulse", cfg_err, 1);
    check("c_valid", m_valid, 0);
    check("c_sync", sync_err, 0);
    fft_length = 13'd8;
    for (int i = 0; i < 5; i++) begin
      send(i, 1'b0);
      check("h_errs", {sync_err, cfg_err}, 0);
      check("h_valid", m_valid, 0);
      check("h_locked", locked, 0);
    end
    // Async reset mid-PASS
    cp_length = 13'd4;
    for (int i = 0; i < 7; i++) send(i, i == 0);
    check("a_pre_valid", m_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("a_valid", m_valid, 0);
    check("a_last", m_last, 0);
    check("a_locked", locked, 0);
    check("a_errs", {sync_err, cfg_err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    run_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
